// File: rtl/mux2_burst_arbiter.sv
// mux2_burst_arbiter
// -----------------------------------------------------------------------------
// Two-requester burst arbiter feeding one registered downstream port.
//
// A requester is granted for a whole burst, which ends on a beat with `last`
// set. Between bursts the arbiter spends exactly one cycle in IDLE to pick the
// next owner. When both requesters are waiting, priority alternates between
// bursts. The beat path goes through a 2:1 select mux steered by the grant and
// lands in a single output register. That register refills in the same cycle
// it drains, so one beat per cycle is sustained while out_ready stays high.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req0_valid/data/last/ready    requester 0 stream
//   req1_valid/data/last/ready    requester 1 stream
//   out_valid/data/last/select    registered output beat and its source id
//   out_ready                     downstream accept
//   busy                          a grant is active (GRANT0 or GRANT1)
//   beat_count                    beats accepted so far in the current burst,
//                                 saturating at all-ones
// -----------------------------------------------------------------------------

// 2:1 select mux, built bit by bit. sel=0 passes a, sel=1 passes b.
module mux2_sel #(
    parameter int W = 1
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign y[gi] = sel ? b[gi] : a[gi];
        end
    endgenerate
endmodule

module mux2_burst_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_last,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_last,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_select,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] beat_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRANT0 = 2'd1,
        S_GRANT1 = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               prio_reg, prio_next;
    logic [CNT_W-1:0]   beat_count_reg, beat_count_next;

    logic               out_valid_reg;
    logic [WIDTH-1:0]   out_data_reg;
    logic               out_last_reg;
    logic               out_select_reg;

    logic               sel;
    logic               granted;
    logic               can_load;
    logic               accept;
    logic [WIDTH+1:0]   mux_y;
    logic               mux_valid;
    logic               mux_last;
    logic [WIDTH-1:0]   mux_data;

    // The grant steers valid, last and data of the owning requester.
    assign sel     = (state_reg == S_GRANT1);
    assign granted = (state_reg == S_GRANT0) || (state_reg == S_GRANT1);

    mux2_sel #(.W(WIDTH + 2)) u_sel_mux (
        .sel (sel),
        .a   ({req0_valid, req0_last, req0_data}),
        .b   ({req1_valid, req1_last, req1_data}),
        .y   (mux_y)
    );

    assign mux_valid = mux_y[WIDTH+1];
    assign mux_last  = mux_y[WIDTH];
    assign mux_data  = mux_y[WIDTH-1:0];

    // The output register can take a new beat when it is empty or draining
    // this cycle.
    assign can_load   = !out_valid_reg || out_ready;
    assign accept     = granted && mux_valid && can_load;

    assign req0_ready = (state_reg == S_GRANT0) && can_load;
    assign req1_ready = (state_reg == S_GRANT1) && can_load;

    always_comb begin
        state_next      = state_reg;
        prio_next       = prio_reg;
        beat_count_next = beat_count_reg;
        case (state_reg)
            S_IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_next = prio_reg ? S_GRANT1 : S_GRANT0;
                end else if (req0_valid) begin
                    state_next = S_GRANT0;
                end else if (req1_valid) begin
                    state_next = S_GRANT1;
                end
            end
            S_GRANT0, S_GRANT1: begin
                // Without an accept the grant is held, so bubbles inside a
                // burst never release it.
                if (accept) begin
                    if (mux_last) begin
                        state_next      = S_IDLE;
                        prio_next       = !sel;
                        beat_count_next = '0;
                    end else if (beat_count_reg != '1) begin
                        beat_count_next = beat_count_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            prio_reg       <= 1'b0;
            beat_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            prio_reg       <= prio_next;
            beat_count_reg <= beat_count_next;
        end
    end

    // Output stage. The payload only moves on accept, so it stays stable
    // while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_select_reg <= 1'b0;
        end else if (accept) begin
            out_valid_reg  <= 1'b1;
            out_data_reg   <= mux_data;
            out_last_reg   <= mux_last;
            out_select_reg <= sel;
        end else if (out_ready) begin
            out_valid_reg  <= 1'b0;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_last   = out_last_reg;
    assign out_select = out_select_reg;
    assign busy       = (state_reg != S_IDLE);
    assign beat_count = beat_count_reg;

endmodule
